fifo_rd_packer: RTL and testbench

//   Read-side consumer of the asynchronous FIFO, in the read clock domain. Pops DATA_WIDTH

---
 rtl/fifo_rd_packer.sv | 135 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops words from a first-word-fall-through FIFO and packs PACK_RATIO of them
// into one registered valid/ready beat. Define PACK_TIMEOUT_EN to flush idle partial beats.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                             rclk,
   input  logic                             rrst,
   input  logic                             fifo_empty,
   input  logic [DATA_WIDTH-1:0]            fifo_rdata,
   output logic                             fifo_r_en,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
   output logic [PACK_RATIO-1:0]            m_keep
);
   localparam int             LCW      = $clog2(PACK_RATIO + 1);
   localparam logic [LCW-1:0] FULL_CNT = LCW'(PACK_RATIO);

   if (PACK_RATIO < 2 || TIMEOUT < 1) begin : g_param_check
      $error("fifo_rd_packer: PACK_RATIO must be >= 2 and TIMEOUT >= 1");
   end

   logic [LCW-1:0]                   lane_cnt_reg;
   logic [LCW-1:0]                   lane_cnt_next;
   logic [LCW-1:0]                   base_lane;
   logic [DATA_WIDTH-1:0]            acc_reg [PACK_RATIO];
   logic [PACK_RATIO-1:0]            fill_mask;
   logic [DATA_WIDTH*PACK_RATIO-1:0] beat_data;

   logic                             m_valid_reg;
   logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_reg;
   logic [PACK_RATIO-1:0]            m_keep_reg;

   logic flush;
   logic acc_full;
   logic out_free;
   logic move;
   logic pop;

   assign acc_full = (lane_cnt_reg == FULL_CNT);
   assign out_free = !m_valid_reg || m_ready;
   assign move     = (acc_full || flush) && out_free;

   // m_ready reaches fifo_r_en combinationally so a full accumulator can drain and refill
   // on the same edge without a bubble.
   assign pop       = !rrst && !fifo_empty && !flush && (!acc_full || move);
   assign fifo_r_en = pop;

   assign base_lane     = move ? '0 : lane_cnt_reg;
   assign lane_cnt_next = base_lane + LCW'(pop);

   for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
      assign fill_mask[gi] = (lane_cnt_reg > LCW'(gi));
      assign beat_data[gi*DATA_WIDTH +: DATA_WIDTH] = fill_mask[gi] ? acc_reg[gi] : '0;

      always_ff @(posedge rclk) begin
         if (pop && (base_lane == LCW'(gi))) begin
            acc_reg[gi] <= fifo_rdata;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         lane_cnt_reg <= '0;
      end else begin
         lane_cnt_reg <= lane_cnt_next;
      end
   end

   // Output stage: loads on move, otherwise holds until the handshake retires the beat.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         m_keep_reg  <= '0;
      end else if (move) begin
         m_valid_reg <= 1'b1;
         m_data_reg  <= beat_data;
         m_keep_reg  <= fill_mask;
      end else if (m_ready) begin
         m_valid_reg <= 1'b0;
      end
   end

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_keep  = m_keep_reg;

`ifdef PACK_TIMEOUT_EN
   localparam int            TW          = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_next;
   logic          flush_reg;
   logic          flush_next;
   logic          partial;

   assign partial = (lane_cnt_reg != '0) && !acc_full;

   // Timer saturates at TIMEOUT; the sticky flush then blocks pops until the beat moves.
   always_comb begin
      timer_next = timer_reg;
      flush_next = flush_reg;
      if (pop || move) begin
         timer_next = '0;
      end else if (partial && !flush_reg && (timer_reg != TIMEOUT_CNT)) begin
         timer_next = timer_reg + 1'b1;
      end
      if (move) begin
         flush_next = 1'b0;
      end else if (timer_reg == TIMEOUT_CNT) begin
         flush_next = 1'b1;
      end
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         timer_reg <= '0;
         flush_reg <= 1'b0;
      end else begin
         timer_reg <= timer_next;
         flush_reg <= flush_next;
      end
   end

   assign flush = flush_reg;
`else
   assign flush = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FWFT FIFO model feeds the DUT and a
// negedge monitor compares every accepted beat against the expected-beat queue.
module tb_fifo_rd_packer;
   localparam int DW = 8;
   localparam int PR = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
   } beat_t;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_r_en;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [31:0]   m_data;
   logic [3:0]    m_keep;

   int total = 0;
   int bad   = 0;

   logic [7:0] fifo_q[$];
   int         fifo_cnt   = 0;
   logic [7:0] fifo_head  = 8'h00;
   logic       gate_empty = 1'b0;
   beat_t      exp_q[$];

   int cyc           = 0;
   int pop_total     = 0;
   int first_pop_cyc = -1;
   int last_pop_cyc  = -1;
   int valid_cycles  = 0;

   assign fifo_empty = gate_empty || (fifo_cnt == 0);
   assign fifo_rdata = fifo_head;

   always #5 rclk = ~rclk;

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT(16)) dut (
      .rclk       (rclk),
      .rrst       (rrst),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_keep     (m_keep)
   );

   task automatic refresh();
      fifo_cnt  = fifo_q.size();
      fifo_head = (fifo_cnt > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push_word(input logic [7:0] w);
      fifo_q.push_back(w);
      refresh();
   endtask

   task automatic exp_beat(input logic [31:0] d, input logic [3:0] k);
      beat_t b;
      b.data = d;
      b.keep = k;
      exp_q.push_back(b);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge rclk);
         #2;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic wait_valid(input string name, input int limit, output int n);
      n = 0;
      while (!m_valid && n < limit) begin
         tick();
         n++;
      end
      total++;
      if (!m_valid) begin
         bad++;
         $display("FAIL %s: m_valid not seen within %0d cycles", name, limit);
      end
   endtask

   task automatic wait_drain(input string name, input int limit, input bit rnd);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < limit) begin
         if (rnd) begin
            gate_empty = ($urandom_range(0, 3) == 0);
            m_ready    = $urandom_range(0, 1) != 0;
         end
         tick();
         n++;
      end
      gate_empty = 1'b0;
      m_ready    = 1'b1;
      total++;
      if (n >= limit) begin
         bad++;
         $display("FAIL %s: %0d beats still pending after %0d cycles", name, exp_q.size(), limit);
      end
   endtask

   // FIFO model: pop is sampled at the edge, queue updated just after it.
   always @(posedge rclk) begin : fifo_model
      logic do_pop;
      do_pop = fifo_r_en;
      cyc++;
      #1;
      if (do_pop) begin
         total++;
         if (fifo_q.size() == 0) begin
            bad++;
            $display("FAIL fifo_underflow: pop with %0d words queued, required >0", fifo_q.size());
         end else begin
            void'(fifo_q.pop_front());
            pop_total++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         refresh();
      end
   end

   always @(negedge rclk) begin : monitor
      beat_t e;
      if (!rrst) begin
         total++;
         if (fifo_r_en && fifo_empty) begin
            bad++;
            $display("FAIL pop_while_empty: fifo_r_en=1 with fifo_empty=1, required fifo_r_en=0");
         end
         if (m_valid) valid_cycles++;
         if (m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat: got data=%h keep=%h, none expected", m_data, m_keep);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e.data || m_keep !== e.keep) begin
                  bad++;
                  $display("FAIL beat: got data=%h keep=%h required data=%h keep=%h",
                           m_data, m_keep, e.data, e.keep);
               end else begin
                  $display("beat ok: data=%h keep=%h", m_data, m_keep);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin : stim
      int n;
      int v0;
      int p0;
      logic [31:0] grp;
      logic [7:0]  w;

      // Reset state; a queued word must not be popped while rrst is high.
      rrst = 1'b1;
      tick(2);
      push_word(8'h11);
      tick();
      check("rst_fifo_r_en", fifo_r_en, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_keep", m_keep, 0);

      // 1: single beat, latency and one-cycle valid.
      exp_beat(32'h44332211, 4'hF);
      m_ready = 1'b1;
      rrst    = 1'b0;
      push_word(8'h22);
      push_word(8'h33);
      push_word(8'h44);
      wait_valid("t1_valid", 20, n);
      check("t1_latency", n, 5);
      tick();
      check("t1_valid_one_cycle", m_valid, 0);

      // 2: backpressure holds beat0 and stalls the FIFO with 4 words left.
      m_ready = 1'b0;
      for (int i = 1; i <= 12; i++) push_word(8'(i));
      exp_beat(32'h04030201, 4'hF);
      exp_beat(32'h08070605, 4'hF);
      exp_beat(32'h0C0B0A09, 4'hF);
      tick(20);
      check("t2_hold_valid", m_valid, 1);
      check("t2_hold_data", m_data, 32'h04030201);
      check("t2_hold_keep", m_keep, 4'hF);
      check("t2_r_en_low", fifo_r_en, 0);
      check("t2_fifo_left", fifo_cnt, 4);
      tick(3);
      check("t2_hold_data_late", m_data, 32'h04030201);
      m_ready = 1'b1;
      wait_drain("t2_drain", 40, 1'b0);
      check("t2_fifo_empty", fifo_cnt, 0);

      // 3: 64 back-to-back words, pops on every cycle.
      gate_empty = 1'b1;
      for (int i = 0; i < 64; i++) begin
         w = 8'(i * 3 + 1);
         push_word(w);
         grp[(i % 4)*8 +: 8] = w;
         if (i % 4 == 3) exp_beat(grp, 4'hF);
      end
      first_pop_cyc = -1;
      p0 = pop_total;
      gate_empty = 1'b0;
      wait_drain("t3_drain", 200, 1'b0);
      check("t3_pop_count", pop_total - p0, 64);
      check("t3_pop_span", last_pop_cyc - first_pop_cyc, 63);

      // 4: reset mid-group discards the partial beat.
      push_word(8'h55);
      push_word(8'h66);
      n = 0;
      while (fifo_cnt != 0 && n < 20) begin
         tick();
         n++;
      end
      check("t4_two_popped", fifo_cnt, 0);
      v0 = valid_cycles;
      rrst = 1'b1;
      tick();
      rrst = 1'b0;
      check("t4_valid_after_rst", m_valid, 0);
      tick(5);
      check("t4_no_beat", valid_cycles - v0, 0);
      exp_beat(32'hA4A3A2A1, 4'hF);
      push_word(8'hA1);
      push_word(8'hA2);
      push_word(8'hA3);
      push_word(8'hA4);
      wait_drain("t4_drain", 30, 1'b0);

      // 5: partial group with no further words.
      push_word(8'hAA);
      push_word(8'hBB);
`ifdef PACK_TIMEOUT_EN
      exp_beat(32'h0000BBAA, 4'b0011);
      tick(3);
      wait_drain("t5_flush", 60, 1'b0);
`else
      v0 = valid_cycles;
      tick(100);
      check("t5_no_beat", valid_cycles - v0, 0);
      check("t5_acc_held", fifo_cnt, 0);
      rrst = 1'b1;
      tick();
      rrst = 1'b0;
`endif

      // 6: random empty gating and backpressure; order and count preserved.
      gate_empty = 1'b1;
      for (int i = 0; i < 40; i++) begin
         w = 8'($urandom);
         push_word(w);
         grp[(i % 4)*8 +: 8] = w;
         if (i % 4 == 3) exp_beat(grp, 4'hF);
      end
      wait_drain("t6_drain", 2000, 1'b1);
      check("t6_fifo_empty", fifo_cnt, 0);
      tick(2);
      check("t6_idle_valid", m_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
